bilat_pixel_packer: RTL and testbench

BILAT_PIXEL_PACKER -- requirements
Module: bilat_pixel_packer

---
 rtl/bilat_pixel_packer_if.sv | 24 ++
 rtl/bilat_pixel_packer.sv | 141 ++++++++++++++
 tb/tb_bilat_pixel_packer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bilat_pixel_packer_if.sv
// Output stream of the bilateral pixel packer: FWFT head word with line/frame side-band flags.
interface bilat_pixel_packer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_eol;
    logic        out_eof;

    modport master (
        output out_valid,
        output out_data,
        output out_eol,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_eol,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/bilat_pixel_packer.sv
// Packs 8-bit filtered pixels into 32-bit words with eol/eof flags and buffers them in a FWFT FIFO.
// Define PACKER_LINE_FLUSH_EN to close (zero-pad) the word at every line end instead of frame end only.
module bilat_pixel_packer #(
    parameter int unsigned LINE_PIXELS = 316,
    parameter int unsigned FRAME_LINES = 236,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bilat_valid,
    input  logic [7:0]                    bilat_out,
    bilat_pixel_packer_if.master          out_if,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned PW = $clog2(LINE_PIXELS + 1);
    localparam int unsigned LCW = $clog2(FRAME_LINES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [PW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [31:0]    part_q, part_d;
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           ovf_q, ovf_d;

    logic [31:0] mem_data [FIFO_DEPTH];
    logic        mem_eol  [FIFO_DEPTH];
    logic        mem_eof  [FIFO_DEPTH];

    logic        last_pix, last_line, last_frame;
    logic        flush, word_eol, word_eof;
    logic        complete, full, pop, push, drop;
    logic [31:0] word;

    assign last_pix   = pix_cnt_q == PW'(LINE_PIXELS - 1);
    assign last_line  = line_cnt_q == LCW'(FRAME_LINES - 1);
    assign last_frame = last_pix && last_line;

`ifdef PACKER_LINE_FLUSH_EN
    assign flush    = last_pix;
    assign word_eol = last_pix;
`else
    assign flush    = last_frame;
    assign word_eol = 1'b0;
`endif
    assign word_eof = last_frame;

    // Bytes above byte_idx in part_q are always zero, so OR-ing in the new byte also zero-pads.
    assign word     = part_q | (32'(bilat_out) << {byte_idx_q, 3'b000});
    assign complete = bilat_valid && ((byte_idx_q == 2'd3) || flush);

    assign full = level_q == LW'(FIFO_DEPTH);
    assign pop  = (level_q != '0) && out_if.out_ready;
    assign push = complete && (!full || pop);
    assign drop = complete && full && !pop;

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        byte_idx_d = byte_idx_q;
        part_d     = part_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q | drop;

        if (bilat_valid) begin
            if (complete) begin
                part_d     = '0;
                byte_idx_d = '0;
            end else begin
                part_d     = word;
                byte_idx_d = byte_idx_q + 2'd1;
            end
            if (last_pix) begin
                pix_cnt_d  = '0;
                line_cnt_d = last_line ? '0 : line_cnt_q + LCW'(1);
            end else begin
                pix_cnt_d = pix_cnt_q + PW'(1);
            end
        end

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            byte_idx_q <= '0;
            part_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            byte_idx_q <= byte_idx_d;
            part_q     <= part_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data[wptr_q] <= word;
            mem_eol[wptr_q]  <= word_eol;
            mem_eof[wptr_q]  <= word_eof;
        end
    end

    // Outputs are gated so an empty FIFO presents zeros rather than stale memory.
    always_comb begin
        out_if.out_valid = level_q != '0;
        out_if.out_data  = '0;
        out_if.out_eol   = 1'b0;
        out_if.out_eof   = 1'b0;
        if (out_if.out_valid) begin
            out_if.out_data = mem_data[rptr_q];
            out_if.out_eol  = mem_eol[rptr_q];
            out_if.out_eof  = mem_eof[rptr_q];
        end
    end

    assign overflow   = ovf_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_bilat_pixel_packer.sv
// Self-checking bench for bilat_pixel_packer: directed tables plus random traffic against a queue model.
module tb_bilat_pixel_packer;
    localparam int LP    = 6;
    localparam int FL    = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        eol;
        logic        eof;
    } word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       bilat_valid;
    logic [7:0] bilat_out;
    logic       overflow;
    logic [2:0] fifo_level;

    bilat_pixel_packer_if ifc ();

    bilat_pixel_packer #(
        .LINE_PIXELS (LP),
        .FRAME_LINES (FL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bilat_valid (bilat_valid),
        .bilat_out   (bilat_out),
        .out_if      (ifc.master),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: frame position, pending bytes, and the FIFO as a bounded queue.
    int         m_pix;
    int         m_line;
    logic [7:0] m_bytes[$];
    word_t      m_fifo[$];
    logic       m_ovf;

    word_t exp_words[$];

    function automatic word_t mk(input logic [31:0] d, input logic l, input logic f);
        word_t w;
        w.data = d;
        w.eol  = l;
        w.eof  = f;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_last_pix();
        return m_pix == LP - 1;
    endfunction

    function automatic bit model_last_frame();
        return (m_pix == LP - 1) && (m_line == FL - 1);
    endfunction

    function automatic bit would_complete();
`ifdef PACKER_LINE_FLUSH_EN
        return (m_bytes.size() == 3) || model_last_pix();
`else
        return (m_bytes.size() == 3) || model_last_frame();
`endif
    endfunction

    function automatic void model_pixel(input logic [7:0] p, output bit done, output word_t w);
        done = would_complete();
        m_bytes.push_back(p);
        w = '0;
        if (done) begin
            for (int i = 0; i < m_bytes.size(); i++) w.data[8*i +: 8] = m_bytes[i];
`ifdef PACKER_LINE_FLUSH_EN
            w.eol = model_last_pix();
`else
            w.eol = 1'b0;
`endif
            w.eof = model_last_frame();
            m_bytes.delete();
        end
        if (model_last_pix()) begin
            m_pix  = 0;
            m_line = (m_line == FL - 1) ? 0 : m_line + 1;
        end else begin
            m_pix++;
        end
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = m_fifo.size() != 0;
        chk("out_valid", ifc.out_valid, ev);
        if (ev) begin
            chk("out_data", ifc.out_data, m_fifo[0].data);
            chk("out_eol", ifc.out_eol, m_fifo[0].eol);
            chk("out_eof", ifc.out_eof, m_fifo[0].eof);
        end
        chk("fifo_level", fifo_level, m_fifo.size());
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic cycle(input logic v, input logic [7:0] p, input logic r);
        bit    pop;
        bit    done;
        word_t w;
        bilat_valid   = v;
        bilat_out     = p;
        ifc.out_ready = r;
        @(posedge clk);
        pop  = (m_fifo.size() != 0) && r;
        done = 1'b0;
        if (v) model_pixel(p, done, w);
        if (pop) void'(m_fifo.pop_front());
        if (done) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else m_ovf = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bilat_valid   = 1'b0;
        bilat_out     = 8'h00;
        ifc.out_ready = 1'b0;
        @(posedge clk);
        m_pix  = 0;
        m_line = 0;
        m_bytes.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
        #1;
        rst = 1'b0;
        chk("reset_out_data", ifc.out_data, 32'h0);
        chk("reset_out_eol", ifc.out_eol, 1'b0);
        chk("reset_out_eof", ifc.out_eof, 1'b0);
        check_outputs();
    endtask

    initial begin
        int guard;
        logic [7:0] px;

`ifdef PACKER_LINE_FLUSH_EN
        exp_words.push_back(mk(32'h04030201, 1'b0, 1'b0));
        exp_words.push_back(mk(32'h00000605, 1'b1, 1'b0));
        exp_words.push_back(mk(32'h0A090807, 1'b0, 1'b0));
        exp_words.push_back(mk(32'h00000C0B, 1'b1, 1'b1));
`else
        exp_words.push_back(mk(32'h04030201, 1'b0, 1'b0));
        exp_words.push_back(mk(32'h08070605, 1'b0, 1'b0));
        exp_words.push_back(mk(32'h0C0B0A09, 1'b0, 1'b1));
`endif

        do_reset();

        // Byte order and single-cycle latency
        cycle(1'b1, 8'h11, 1'b1);
        cycle(1'b1, 8'h22, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        chk("order_not_yet", ifc.out_valid, 1'b0);
        cycle(1'b1, 8'h44, 1'b1);
        chk("order_valid", ifc.out_valid, 1'b1);
        chk("order_word", ifc.out_data, 32'h44332211);
        cycle(1'b0, 8'h00, 1'b1);
        chk("order_one_cycle", ifc.out_valid, 1'b0);

        // Line/frame flush table: pixels 1..12, then drain and compare with the word table
        do_reset();
        for (int i = 1; i <= 12; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("flush_level", fifo_level, exp_words.size());
        for (int i = 0; i < exp_words.size(); i++) begin
            chk("flush_valid", ifc.out_valid, 1'b1);
            chk("flush_word", ifc.out_data, exp_words[i].data);
            chk("flush_eol", ifc.out_eol, exp_words[i].eol);
            chk("flush_eof", ifc.out_eof, exp_words[i].eof);
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk("flush_drained", ifc.out_valid, 1'b0);

        // Overflow: 20 pixels with no consumer
        do_reset();
        for (int i = 1; i <= 20; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("ovf_level", fifo_level, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_first_word", ifc.out_data, 32'h04030201);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("ovf_drained", ifc.out_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Full FIFO with a pop in the same cycle as the next push
        do_reset();
        px    = 8'h30;
        guard = 0;
        while (m_fifo.size() < DEPTH && guard < 100) begin
            cycle(1'b1, px, 1'b0);
            px++;
            guard++;
        end
        while (!would_complete() && guard < 100) begin
            cycle(1'b1, px, 1'b0);
            px++;
            guard++;
        end
        chk("full_setup_bound", guard < 100, 1'b1);
        chk("full_setup_level", fifo_level, 3'd4);
        cycle(1'b1, px, 1'b1);
        chk("full_pop_level", fifo_level, 3'd4);
        chk("full_pop_no_ovf", overflow, 1'b0);

        // Reset after two pixels of a word discards the partial word
        do_reset();
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b1, 8'h66, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
        chk("midrst_word", ifc.out_data, 32'hA3A2A1A0);
        chk("midrst_level", fifo_level, 3'd1);
        chk("midrst_ovf", overflow, 1'b0);

        // Random traffic against the model, with a reset midway to clear the sticky flag
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic v;
            logic r;
            if (i == 750) do_reset();
            v = $urandom_range(0, 99) < 70;
            r = $urandom_range(0, 99) < ((i % 300) < 150 ? 30 : 85);
            cycle(v, 8'($urandom), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
